// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices, FSM
// state encoding, CAUSE layout and the fixed-priority helper.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_REG_MASK  = 2'd0;
  localparam logic [1:0] IRQ_REG_EDGE  = 2'd1;
  localparam logic [1:0] IRQ_REG_PEND  = 2'd2;
  localparam logic [1:0] IRQ_REG_CAUSE = 2'd3;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  localparam int CAUSE_BUSY_BIT = 31;
  localparam int CAUSE_ID_LSB   = 0;
  localparam int CAUSE_ID_W     = 5;

  // Bit 0 has the highest priority; returns 0 when nothing is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchronizer for an asynchronous interrupt line, followed by a
// delay flop and a registered rising-edge detector.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_s_d  <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_s_d;
    end
  end

  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = r_rise;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: masks, edge/level pending capture and a one-at-a-time
// request/service sequencer driving the CP0 ir_in line.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             irq_out,
  input  logic             irq_taken,
  input  logic             eret,
  output logic [4:0]       irq_id,
  output logic             busy
);

  logic [N_SRC-1:0] r_mask, r_edge, r_pend;
  logic [4:0]       r_irq_id;
  irq_state_t       r_state, w_state_next;

  logic [N_SRC-1:0] w_s, w_rise, w_eligible, w_w1c, w_ack;
  logic [31:0]      w_elig32, w_edge32;
  logic             w_ack_en;
  logic             w_unused_wdata;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (irq_src[i]),
      .s    (w_s[i]),
      .rise (w_rise[i])
    );
  end

  assign w_eligible     = r_pend & r_mask;
  assign w_elig32       = 32'(w_eligible);
  assign w_edge32       = 32'(r_edge);
  assign w_w1c          = (reg_we && reg_addr == IRQ_REG_PEND) ? reg_wdata[N_SRC-1:0] : '0;
  assign w_unused_wdata = &{1'b0, reg_wdata};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ack_en     = 1'b0;
    unique case (r_state)
      IRQ_IDLE:    if (|w_eligible) w_state_next = IRQ_REQ;
      IRQ_REQ: begin
        if (irq_taken) begin
          w_state_next = IRQ_SERVICE;
          w_ack_en     = w_edge32[r_irq_id];
        end else if (!w_elig32[r_irq_id]) begin
          w_state_next = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: if (eret) w_state_next = IRQ_IDLE;
      default:     w_state_next = IRQ_IDLE;
    endcase
  end

  always_comb begin
    w_ack = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_ack[i] = w_ack_en && (r_irq_id == 5'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IRQ_IDLE;
      r_irq_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IRQ_IDLE && |w_eligible) r_irq_id <= lowest_set(w_elig32);
    end
  end

  // Level bits mirror the synchronized line; edge bits are sticky, and a new
  // rise outranks both software clear and auto-acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      if (reg_we && reg_addr == IRQ_REG_MASK) r_mask <= reg_wdata[N_SRC-1:0];
      if (reg_we && reg_addr == IRQ_REG_EDGE) r_edge <= reg_wdata[N_SRC-1:0];
      r_pend <= (w_s & ~r_edge) | (r_edge & (w_rise | (r_pend & ~w_w1c & ~w_ack)));
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      IRQ_REG_MASK: reg_rdata = 32'(r_mask);
      IRQ_REG_EDGE: reg_rdata = 32'(r_edge);
      IRQ_REG_PEND: reg_rdata = 32'(r_pend);
      default: begin
        reg_rdata[CAUSE_BUSY_BIT]                = busy;
        reg_rdata[CAUSE_ID_LSB +: CAUSE_ID_W]    = r_irq_id;
      end
    endcase
  end

  assign irq_out = (r_state == IRQ_REQ);
  assign busy    = (r_state != IRQ_IDLE);
  assign irq_id  = r_irq_id;

endmodule
